// File: rtl/part_6_accumulator_if.sv
// part_6_accumulator_if: operand/result handshake bundle for the add/sub accumulator.
interface part_6_accumulator_if #(parameter int WIDTH = 32, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_acc;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;
  modport master (
    output in_valid, in_data, in_sub, in_clear, out_ready,
    input  in_ready, out_valid, out_acc, out_carry, out_ovf, out_zero, op_count
  );
  modport slave (
    input  in_valid, in_data, in_sub, in_clear, out_ready,
    output in_ready, out_valid, out_acc, out_carry, out_ovf, out_zero, op_count
  );
endinterface

// File: rtl/part_6_accumulator.sv
// part_6_accumulator: handshaked add/sub accumulator with flags and saturating op counter.
// Define ACC_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module part_5_top_module #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {{WIDTH{1'b0}}, sub};
endmodule

module part_6_accumulator #(parameter int WIDTH = 32, parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  part_6_accumulator_if.slave bus
);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state;
  logic [WIDTH-1:0] acc, op, sum, nxt, res;
  logic             sub, clr, carry, ovf, zero, valid, cout, v;
  logic [CNT_W-1:0] cnt;
  part_5_top_module #(.WIDTH(WIDTH)) u_stage (.a(acc), .b(op), .sub(sub), .sum(sum), .cout(cout));
  assign v = sub ? (acc[M] != op[M]) && (sum[M] != acc[M])
                 : (acc[M] == op[M]) && (sum[M] != acc[M]);
`ifdef ACC_SAT_EN
  // on overflow the true result carries the sign of the old accumulator
  assign nxt = v ? {acc[M], {M{~acc[M]}}} : sum;
`else
  assign nxt = sum;
`endif
  assign res = clr ? op : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      op    <= '0;
      sub   <= 1'b0;
      clr   <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b1;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op    <= bus.in_data;
          sub   <= bus.in_sub & ~bus.in_clear;
          clr   <= bus.in_clear;
          state <= EXEC;
        end
        EXEC: begin
          acc   <= res;
          carry <= !clr && cout;
          ovf   <= !clr && v;
          zero  <= res == '0;
          cnt   <= &cnt ? cnt : cnt + 1'b1;
          valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.out_ready) begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state == IDLE && !rst;
  assign bus.out_valid = valid;
  assign bus.out_acc   = acc;
  assign bus.out_carry = carry;
  assign bus.out_ovf   = ovf;
  assign bus.out_zero  = zero;
  assign bus.op_count  = cnt;
endmodule
